// File: rtl/ptp_round_scheduler.sv
// ============================================================================
// Module   : ptp_round_scheduler
// Brief    : Runs 2^ROUNDS_LOG2 PTP measurement rounds, averages accepted
//            travel times and exposes control/status over an Avalon-MM slave.
//            Optional WAIT timeout is enabled by defining PTP_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ptp_round_scheduler #(
    parameter int ROUNDS_LOG2    = 3,
    parameter int GAP_CYCLES     = 7000,
    parameter int MAX_FAILS      = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] avalon_slave_address,
    input  logic        avalon_slave_write,
    input  logic [31:0] avalon_slave_writedata,
    input  logic        avalon_slave_read,
    output logic [31:0] avalon_slave_readdata,
    output logic        avalon_slave_waitrequest,
    output logic        ptp_start,
    output logic        ptp_role,
    input  logic        ptp_conv_finished,
    input  logic [31:0] ptp_travel_time,
    output logic        sched_busy,
    output logic        sched_done,
    output logic [31:0] avg_travel_time
);

    localparam int c_SUM_W = 32 + ROUNDS_LOG2;
    localparam int c_CNT_W = ROUNDS_LOG2 + 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_ROUNDS   = c_CNT_W'(1 << ROUNDS_LOG2);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = (GAP_CYCLES > 1) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]         c_MAX_FAILS = (MAX_FAILS > 255) ? 8'd255 : 8'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_start;
    logic                 r_role;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [7:0]           r_fail_cnt;
    logic [c_SUM_W-1:0]   r_sum;
    logic [c_CNT_W-1:0]   r_count;
    logic [31:0]          r_avg;
    logic [31:0]          r_last;
    logic [31:0]          r_rdata;
    logic                 r_wait_flag;
    logic                 r_conv_prev;
    logic [c_GAP_W-1:0]   r_gap_cnt;

    logic [7:0]           w_idx;
    logic                 w_wait_req;
    logic                 w_wr_en;
    logic                 w_go;
    logic                 w_abort;
    logic                 w_rise;
    logic                 w_timed_out;
    logic                 w_accept;
    logic [7:0]           w_fail_next;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [31:0]          w_rd_data;
    logic                 w_unused_bits;

`ifdef PTP_SCHED_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = (TIMEOUT_CYCLES > 1) ? c_TO_W'(TIMEOUT_CYCLES - 1) : '0;
    logic [c_TO_W-1:0]    r_wait_cnt;
    logic                 r_timed_out;
    assign w_timed_out = r_timed_out;
`else
    assign w_timed_out = 1'b0;
`endif

    assign w_idx         = avalon_slave_address[15:8];
    assign w_wait_req    = avalon_slave_read && r_wait_flag;
    assign w_wr_en       = avalon_slave_write && !w_wait_req;
    assign w_go          = w_wr_en && (w_idx == 8'h00) && avalon_slave_writedata[0];
    assign w_abort       = w_wr_en && (w_idx == 8'h00) && avalon_slave_writedata[2];
    assign w_rise        = ptp_conv_finished && !r_conv_prev;
    assign w_accept      = !w_timed_out && (ptp_travel_time > 32'd1);
    assign w_fail_next   = (r_fail_cnt == 8'hFF) ? 8'hFF : r_fail_cnt + 8'd1;
    assign w_cnt_next    = r_count + c_CNT_W'(1);
    assign w_unused_bits = ^{avalon_slave_address[7:0], avalon_slave_writedata[31:3]};

    always_comb begin
        w_rd_data = 32'hDEADBEEF;
        case (w_idx)
            8'h00:   w_rd_data = {29'd0, r_error, r_done, r_busy};
            8'h01:   w_rd_data = r_avg;
            8'h02:   w_rd_data = r_last;
            8'h03:   w_rd_data = {24'd0, r_fail_cnt};
            default: w_rd_data = 32'hDEADBEEF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_role      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_fail_cnt  <= 8'd0;
            r_sum       <= '0;
            r_count     <= '0;
            r_avg       <= 32'd0;
            r_last      <= 32'd0;
            r_rdata     <= 32'd0;
            r_wait_flag <= 1'b1;
            r_conv_prev <= 1'b0;
            r_gap_cnt   <= '0;
`ifdef PTP_SCHED_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
`endif
        end else begin
            r_conv_prev <= ptp_conv_finished;
            r_start     <= 1'b0;

            // One wait cycle per read: data is captured while waitrequest is high.
            if (!avalon_slave_read) begin
                r_wait_flag <= 1'b1;
            end else if (r_wait_flag) begin
                r_wait_flag <= 1'b0;
                r_rdata     <= w_rd_data;
            end

            case (r_state)
                S_IDLE: begin
                end
                S_START: begin
                    r_state <= S_WAIT;
`ifdef PTP_SCHED_TIMEOUT_EN
                    r_wait_cnt  <= '0;
                    r_timed_out <= 1'b0;
`endif
                end
                S_WAIT: begin
                    if (w_rise) begin
                        r_state <= S_ACCUM;
`ifdef PTP_SCHED_TIMEOUT_EN
                    end else if (r_wait_cnt == c_TO_LAST) begin
                        r_timed_out <= 1'b1;
                        r_state     <= S_ACCUM;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
`endif
                    end
                end
                S_ACCUM: begin
                    r_gap_cnt <= '0;
                    if (w_accept) begin
                        r_sum   <= r_sum + c_SUM_W'(ptp_travel_time);
                        r_count <= w_cnt_next;
                        r_last  <= ptp_travel_time;
                        r_state <= (w_cnt_next == c_ROUNDS) ? S_DONE : S_GAP;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        if (w_fail_next >= c_MAX_FAILS) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                S_DONE: begin
                    if (!w_abort) begin
                        r_avg <= r_sum[c_SUM_W-1:ROUNDS_LOG2];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Register writes act after the state update so an ACCUM sample is never dropped.
            if (w_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_start <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_go && (r_state == S_IDLE) && !w_abort) begin
                r_state    <= S_START;
                r_start    <= 1'b1;
                r_role     <= avalon_slave_writedata[1];
                r_sum      <= '0;
                r_count    <= '0;
                r_fail_cnt <= 8'd0;
                r_error    <= 1'b0;
                r_done     <= 1'b0;
                r_busy     <= 1'b1;
            end
        end
    end

    assign avalon_slave_readdata    = r_rdata;
    assign avalon_slave_waitrequest = w_wait_req;
    assign ptp_start                = r_start;
    assign ptp_role                 = r_role;
    assign sched_busy               = r_busy;
    assign sched_done               = r_done;
    assign avg_travel_time          = r_avg;

endmodule

`default_nettype wire

// File: doc/ptp_round_scheduler.md
PTP_ROUND_SCHEDULER -- requirements
Module: ptp_round_scheduler

Interface
REQ-001 SHALL have parameters: ROUNDS_LOG2, default 3, averaged rounds = 2^ROUNDS_LOG2.
REQ-002 SHALL have parameters: GAP_CYCLES, default 7000, idle clocks between rounds.
REQ-003 SHALL have parameters: MAX_FAILS, default 16, rejected rounds before abort.
REQ-004 SHALL have parameters: TIMEOUT_CYCLES, default 50000000, per-round wait limit.
REQ-005 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: avalon_slave_address  in  16; avalon_slave_write  in  1; avalon_slave_writedata  in  32; avalon_slave_read  in  1; avalon_slave_readdata  out  32; avalon_slave_waitrequest  out  1.
REQ-007 SHALL have ports: ptp_start  out  1  one-cycle round-start pulse; ptp_role  out  1  1=master.
REQ-008 SHALL have ports: ptp_conv_finished  in  1  round complete; ptp_travel_time  in  32  measured cycles.
REQ-009 SHALL have ports: sched_busy  out  1; sched_done  out  1; avg_travel_time  out  32.

Function
REQ-010 SHALL decode register index as avalon_slave_address>>8.
REQ-011 SHALL implement write 0x00: bit0 go, bit1 role, bit2 abort; other indices ignored.
REQ-012 SHALL implement read 0x00 = {29'd0, error, sched_done, sched_busy}; 0x01 avg_travel_time; 0x02 last accepted sample; 0x03 {24'd0, fail_cnt}; other indices 32'hDEADBEEF.
REQ-013 SHALL drive waitrequest = read && wait_flag; wait_flag is set each idle cycle and cleared one cycle after read, so readdata is valid exactly one cycle after read asserts.
REQ-014 SHALL accept writes only when waitrequest is low.
REQ-015 SHALL use FSM states IDLE, START, WAIT, ACCUM, GAP, DONE.
REQ-016 SHALL leave IDLE for START on go; it SHALL latch role into ptp_role, clear sum, sample count, fail_cnt, error and sched_done, and set sched_busy.
REQ-017 SHALL go go while busy -> ignored.
REQ-018 SHALL pulse ptp_start high exactly one cycle in START, then enter WAIT.
REQ-019 SHALL, in WAIT, accept only a rising edge of ptp_conv_finished (registered previous value low), ignoring a level already high on entry.
REQ-020 SHALL, in ACCUM (one cycle), accept sample if ptp_travel_time > 1: sum += sample (width 32+ROUNDS_LOG2, no overflow), count++, last sample updated.
REQ-021 SHALL, in ACCUM, reject samples 0 or 1 and increment fail_cnt (8-bit, saturating at 255).
REQ-022 SHALL go ACCUM -> DONE when count reaches 2^ROUNDS_LOG2.
REQ-023 SHALL go ACCUM -> IDLE with error=1 when fail_cnt reaches MAX_FAILS.
REQ-024 SHALL otherwise go ACCUM -> GAP.
REQ-025 SHALL hold GAP for GAP_CYCLES clocks, then go to START.
REQ-026 SHALL, in DONE (one cycle), set avg_travel_time = sum >> ROUNDS_LOG2, set sched_done=1, clear sched_busy, and return to IDLE.
REQ-027 SHALL hold sched_done until next go or reset.
REQ-028 SHALL, on abort in any non-IDLE state, enter IDLE next cycle with sched_busy=0, no ptp_start, avg unchanged, sched_done=0.
REQ-029 SHALL give abort priority over go in the same write.
REQ-030 SHALL, when ACCUM and a simultaneous write coincide, process the write after the ACCUM update; no sample is lost.

Reset
REQ-031 SHALL, on reset, asynchronously set state IDLE; ptp_start, ptp_role, sched_busy, sched_done, error, fail_cnt, sum, count = 0; avg_travel_time = 0; last sample = 0; readdata = 0; wait_flag = 1.
REQ-032 SHALL, on reset mid-round, discard partial sum; the next go starts from zero.

Configuration
REQ-033 SHALL, when PTP_SCHED_TIMEOUT_EN is defined, count WAIT cycles; reaching TIMEOUT_CYCLES with no rising edge counts as a rejected round (fail_cnt++) and proceeds per REQ-023/REQ-024.
REQ-034 SHALL, without PTP_SCHED_TIMEOUT_EN, wait indefinitely in WAIT with no timeout counter logic.

Verification
REQ-035 SHALL cover: ROUNDS_LOG2=3, go with role=1, 8 rounds returning 1000..1007 -> avg 1003, sched_done=1, ptp_start pulsed 8 times, each 1 cycle.
REQ-036 SHALL cover: ptp_conv_finished already high at go -> no sample until low then high; single sample taken per edge.
REQ-037 SHALL cover: MAX_FAILS=16, every round returns travel_time=1 -> after 16 rounds error=1, busy=0, done=0, read 0x03 = 16.
REQ-038 SHALL cover: abort written during GAP -> IDLE next cycle, no further ptp_start, read 0x00 = 0.
REQ-039 SHALL cover: read any index -> waitrequest high first cycle, data valid second; read 0x05 -> 32'hDEADBEEF.
REQ-040 SHALL cover, with PTP_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100: no conv_finished -> fail_cnt increments every 100 WAIT cycles plus GAP; without the macro, busy remains high indefinitely.
